frog_hop_ctrl: RTL and testbench

- Sits between the Nios keycode PIO export and the frog motion block.
- Converts raw 16-bit USB keycodes into frame-aligned, one-frame-wide hop requests (up/down/left/right), so each press moves the frog exactly one step.
- Adds a post-hop cooldown, optional hold-to-repeat, and a freeze input that blocks movement during death/respawn.
- Runs on Clk and drives the frog's up/down/left/right inputs, plus LEDG direction and a hop counter for HEX.

---
 rtl/frog_hop_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_frog_hop_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_hop_ctrl.sv
// -----------------------------------------------------------------------------
// frog_hop_ctrl
//
// Turns raw USB keycodes from the Nios PIO into frame-aligned hop requests for
// the frog motion block. Each press produces exactly one request that is high
// for one frame, followed by a cooldown. A freeze input (death/respawn) blocks
// movement until the key has been released.
//
// Optional feature (compile-time macro FROG_HOP_REPEAT_EN):
//   defined   -> holding a direction auto-repeats the hop
//   undefined -> one hop per press, REPEAT_DELAY / REPEAT_RATE unused
//
// Ports (all in the Clk domain except frame_clk):
//   Clk        50 MHz system clock
//   Reset_n    synchronous reset, active-low
//   frame_clk  VGA vertical sync, asynchronous to Clk
//   keycode    two USB key bytes, low byte has priority
//   freeze     1 = hops forbidden, forces release-wait
//   up/down/left/right  hop requests, one frame wide, mutually exclusive
//   last_dir   one-hot last hop direction {left,up,down,right}
//   hop_count  total hops issued, wraps 255 -> 0
// -----------------------------------------------------------------------------
module frog_hop_ctrl #(
  parameter int unsigned HOP_COOLDOWN = 4,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter int unsigned CNT_W        = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  input  logic        freeze,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic [3:0]  last_dir,
  output logic [7:0]  hop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOP,
    S_COOL,
    S_HELD,
    S_WAIT_REL
  } state_t;

  // Direction codes share the last_dir bit layout so a request can be copied
  // straight into last_dir.
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam logic [CNT_W-1:0] L_COOL_INIT =
    (HOP_COOLDOWN == 0) ? '0 : CNT_W'(HOP_COOLDOWN - 1);

  function automatic logic [3:0] decode_byte(input logic [7:0] b);
    case (b)
      8'h52:   decode_byte = DIR_UP;
      8'h51:   decode_byte = DIR_DOWN;
      8'h50:   decode_byte = DIR_LEFT;
      8'h4F:   decode_byte = DIR_RIGHT;
      default: decode_byte = DIR_NONE;
    endcase
  endfunction

  logic             r_sync1, r_sync2, r_sync3;
  logic             w_tick;
  logic [3:0]       w_key_lo, w_key;

  state_t           r_state, w_state_nx;
  logic [3:0]       r_dir, w_dir_nx;
  logic [3:0]       r_req, w_req_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [7:0]       r_hop_count, w_hop_count_nx;
  logic [3:0]       r_last_dir, w_last_dir_nx;

`ifdef FROG_HOP_REPEAT_EN
  localparam logic [CNT_W-1:0] L_DELAY   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] L_RATE_M1 = CNT_W'(REPEAT_RATE - 1);

  logic             r_first, w_first_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_repeat_due;

  // cnt holds the number of HELD ticks already spent in the same direction,
  // saturating at all-ones. The first repeat fires on HELD tick DELAY+1,
  // later repeats every RATE HELD ticks.
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_repeat_due = r_first ? (r_cnt == L_DELAY) : (r_cnt == L_RATE_M1);
`endif

  // Third flop only feeds the edge detector; the tick is one Clk wide and the
  // registered outputs change on the third Clk edge after frame_clk rises.
  assign w_tick   = r_sync2 & ~r_sync3;
  assign w_key_lo = decode_byte(keycode[7:0]);
  assign w_key    = (w_key_lo != DIR_NONE) ? w_key_lo : decode_byte(keycode[15:8]);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx     = r_state;
    w_dir_nx       = r_dir;
    w_req_nx       = r_req;
    w_cnt_nx       = r_cnt;
    w_hop_count_nx = r_hop_count;
    w_last_dir_nx  = r_last_dir;
`ifdef FROG_HOP_REPEAT_EN
    w_first_nx     = r_first;
`endif

    if (freeze) begin
      // Freeze acts on any Clk, tick or not; count and last_dir survive.
      w_state_nx = S_WAIT_REL;
      w_req_nx   = DIR_NONE;
      w_cnt_nx   = '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_key != DIR_NONE) begin
            w_dir_nx   = w_key;
            w_req_nx   = w_key;
            w_state_nx = S_HOP;
`ifdef FROG_HOP_REPEAT_EN
            w_first_nx = 1'b1;
`endif
          end
        end
        S_HOP: begin
          // The hop is only counted when its pulse completes.
          w_req_nx       = DIR_NONE;
          w_hop_count_nx = r_hop_count + 8'd1;
          w_last_dir_nx  = r_dir;
          if (HOP_COOLDOWN > 0) begin
            w_state_nx = S_COOL;
            w_cnt_nx   = L_COOL_INIT;
          end else begin
            w_state_nx = S_HELD;
            w_cnt_nx   = '0;
          end
        end
        S_COOL: begin
          if (r_cnt == '0) begin
            w_state_nx = S_HELD;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        S_HELD: begin
          if (w_key == DIR_NONE) begin
            w_state_nx = S_IDLE;
          end else if (w_key != r_dir) begin
            w_dir_nx   = w_key;
            w_req_nx   = w_key;
            w_state_nx = S_HOP;
`ifdef FROG_HOP_REPEAT_EN
            w_first_nx = 1'b1;
`endif
          end else begin
`ifdef FROG_HOP_REPEAT_EN
            if (w_repeat_due) begin
              w_req_nx   = r_dir;
              w_state_nx = S_HOP;
              w_cnt_nx   = '0;
              w_first_nx = 1'b0;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
`endif
          end
        end
        S_WAIT_REL: begin
          if (w_key == DIR_NONE) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // blocking here would make the synchronizer chain collapse into one flop.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_state     <= S_IDLE;
      r_dir       <= DIR_NONE;
      r_req       <= DIR_NONE;
      r_cnt       <= '0;
      r_hop_count <= 8'd0;
      r_last_dir  <= DIR_NONE;
    end else begin
      r_sync1     <= frame_clk;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_state     <= w_state_nx;
      r_dir       <= w_dir_nx;
      r_req       <= w_req_nx;
      r_cnt       <= w_cnt_nx;
      r_hop_count <= w_hop_count_nx;
      r_last_dir  <= w_last_dir_nx;
    end
  end

`ifdef FROG_HOP_REPEAT_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) r_first <= 1'b0;
    else          r_first <= w_first_nx;
  end
`endif

  assign right     = r_req[0];
  assign down      = r_req[1];
  assign up        = r_req[2];
  assign left      = r_req[3];
  assign last_dir  = r_last_dir;
  assign hop_count = r_hop_count;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_hop_ctrl
//
// Self-checking bench for frog_hop_ctrl: a decode vector table, hand-written
// multi-cycle sequences (reset, tap latency, direction change, hold/repeat,
// freeze, reset mid-hop) and a randomized run compared against a frame-level
// reference model built on hop timestamps.
// -----------------------------------------------------------------------------
module tb_frog_hop_ctrl;

  localparam int HOP_COOLDOWN = 4;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 8;
  localparam int CNT_W        = 6;

`ifdef FROG_HOP_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        freeze = 1'b0;
  logic        up, down, left, right;
  logic [3:0]  last_dir;
  logic [7:0]  hop_count;
  logic [3:0]  req;

  assign req = {left, up, down, right};

  frog_hop_ctrl #(
    .HOP_COOLDOWN(HOP_COOLDOWN),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .keycode  (keycode),
    .freeze   (freeze),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .last_dir (last_dir),
    .hop_count(hop_count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Arrow lookup: bit position in {left,up,down,right} for each arrow code.
  function automatic logic [3:0] arrow_of(input logic [7:0] b);
    logic [7:0] codes [4];
    logic [3:0] r;
    codes = '{8'h4F, 8'h51, 8'h52, 8'h50};
    r = 4'b0000;
    for (int i = 0; i < 4; i++) if (b == codes[i]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] key_dir(input logic [15:0] k);
    logic [3:0] lo;
    lo = arrow_of(k[7:0]);
    return (lo != 4'b0000) ? lo : arrow_of(k[15:8]);
  endfunction

  // One frame: inputs applied at a negedge together with the frame_clk rise,
  // ends on a negedge after the tick has taken effect.
  task automatic frame(input logic [15:0] k, input logic f);
    keycode   = k;
    freeze    = f;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    freeze    = 1'b0;
    keycode   = 16'h0000;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one step per frame. Tracks the tick of the last hop
  // request; the pulse and cooldown form a blackout window after it, then the
  // key is "held" from a known start tick.
  // ---------------------------------------------------------------------------
  localparam int MODE_FREE = 0;
  localparam int MODE_HELD = 1;
  localparam int MODE_WAIT = 2;

  int         m_t, m_hop_t, m_mode, m_hold_start;
  bit         m_first, m_pending;
  logic [3:0] m_req, m_dir, m_last;
  logic [7:0] m_count;

  task automatic model_reset();
    m_t = 0; m_hop_t = -1000; m_mode = MODE_FREE; m_hold_start = 0;
    m_first = 1'b0; m_pending = 1'b0;
    m_req = 4'b0; m_dir = 4'b0; m_last = 4'b0; m_count = 8'd0;
  endtask

  task automatic model_fire(input logic [3:0] d, input bit fresh);
    m_req = d; m_dir = d; m_hop_t = m_t; m_pending = 1'b1;
    m_first = fresh; m_mode = MODE_FREE;
  endtask

  task automatic model_step(input logic [15:0] k, input logic f);
    logic [3:0] kd;
    kd = key_dir(k);
    m_req = 4'b0;
    if (f) begin
      m_pending = 1'b0;
      m_hop_t   = -1000;
      m_mode    = MODE_WAIT;
    end else begin
      if (m_pending && m_t == m_hop_t + 1) begin
        m_count   = m_count + 8'd1;
        m_last    = m_dir;
        m_pending = 1'b0;
      end
      if (m_mode == MODE_WAIT) begin
        if (kd == 4'b0) m_mode = MODE_FREE;
      end else if (m_t <= m_hop_t + 1 + HOP_COOLDOWN) begin
        if (m_t == m_hop_t + 1 + HOP_COOLDOWN) begin
          m_mode       = MODE_HELD;
          m_hold_start = m_t;
        end
      end else if (m_mode == MODE_FREE) begin
        if (kd != 4'b0) model_fire(kd, 1'b1);
      end else begin
        if (kd == 4'b0) m_mode = MODE_FREE;
        else if (kd != m_dir) model_fire(kd, 1'b1);
        else if (REP_EN && (m_t - m_hold_start) ==
                 (m_first ? REPEAT_DELAY + 1 : REPEAT_RATE)) model_fire(kd, 1'b0);
      end
    end
    m_t++;
  endtask

  typedef struct {
    logic [15:0] key;
    logic [3:0]  exp_req;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] pick_key(input int idx);
    logic [15:0] pool [10];
    pool = '{16'h0000, 16'h0000, 16'h0052, 16'h0051, 16'h0050,
             16'h004F, 16'h5200, 16'h4F07, 16'h5152, 16'h1234};
    return pool[idx];
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_last;
    logic [7:0] exp_cnt;
    int         got_q[$];
    int         exp_q[$];
    logic [3:0] other_seen;

    vecs[0]  = '{16'h0052, 4'b0100};
    vecs[1]  = '{16'h0051, 4'b0010};
    vecs[2]  = '{16'h0050, 4'b1000};
    vecs[3]  = '{16'h004F, 4'b0001};
    vecs[4]  = '{16'h4F07, 4'b0001};
    vecs[5]  = '{16'h5152, 4'b0100};
    vecs[6]  = '{16'h5200, 4'b0100};
    vecs[7]  = '{16'h0700, 4'b0000};
    vecs[8]  = '{16'h1234, 4'b0000};
    vecs[9]  = '{16'h5051, 4'b0010};
    vecs[10] = '{16'h4F00, 4'b0001};

    // ---- reset with an arrow held, no frame edges ----
    @(negedge Clk);
    Reset_n = 1'b0; keycode = 16'h0052; frame_clk = 1'b0; freeze = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_req", {28'd0, req}, 32'd0);
    check("rst_last", {28'd0, last_dir}, 32'd0);
    check("rst_count", {24'd0, hop_count}, 32'd0);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    check("rst_idle_no_tick", {28'd0, req}, 32'd0);
    frame(16'h0052, 1'b0);
    check("rst_first_tick_up", {28'd0, req}, 32'h4);

    // ---- decode table, each entry from IDLE ----
    do_reset();
    exp_last = 4'b0; exp_cnt = 8'd0;
    for (int i = 0; i < 11; i++) begin
      frame(vecs[i].key, 1'b0);
      check($sformatf("vec%0d_req", i), {28'd0, req}, {28'd0, vecs[i].exp_req});
      frame(16'h0000, 1'b0);
      if (vecs[i].exp_req != 4'b0) begin
        exp_last = vecs[i].exp_req;
        exp_cnt  = exp_cnt + 8'd1;
      end
      check($sformatf("vec%0d_cleared", i), {28'd0, req}, 32'd0);
      check($sformatf("vec%0d_last", i), {28'd0, last_dir}, {28'd0, exp_last});
      check($sformatf("vec%0d_count", i), {24'd0, hop_count}, {24'd0, exp_cnt});
      repeat (HOP_COOLDOWN + 1) frame(16'h0000, 1'b0);
    end

    // ---- single tap: latency and one-frame width ----
    do_reset();
    keycode = 16'h0052; frame_clk = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    check("tap_lat2", {31'd0, up}, 32'd0);
    @(posedge Clk); #1;
    check("tap_lat3", {31'd0, up}, 32'd1);
    @(negedge Clk);
    keycode = 16'h0000;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    check("tap_held_frame", {31'd0, up}, 32'd1);
    frame(16'h0000, 1'b0);
    check("tap_fall", {28'd0, req}, 32'd0);
    check("tap_count", {24'd0, hop_count}, 32'd1);
    check("tap_last", {28'd0, last_dir}, 32'h4);

    // ---- direction change once back in HELD ----
    do_reset();
    frame(16'h0050, 1'b0);
    check("chg_left", {28'd0, req}, 32'h8);
    frame(16'h0050, 1'b0);
    check("chg_last_left", {28'd0, last_dir}, 32'h8);
    repeat (HOP_COOLDOWN) frame(16'h0050, 1'b0);
    check("chg_quiet_cool", {28'd0, req}, 32'd0);
    frame(16'h004F, 1'b0);
    check("chg_right", {28'd0, req}, 32'h1);
    frame(16'h004F, 1'b0);
    check("chg_last_right", {28'd0, last_dir}, 32'h1);
    check("chg_count", {24'd0, hop_count}, 32'd2);

    // ---- hold down for 60 frames ----
    do_reset();
    other_seen = 4'b0;
    for (int f = 0; f < 60; f++) begin
      frame(16'h0051, 1'b0);
      if (down) got_q.push_back(f);
      other_seen = other_seen | (req & 4'b1101);
    end
    exp_q.push_back(0);
    if (REP_EN) begin
      exp_q.push_back(1 + HOP_COOLDOWN + REPEAT_DELAY + 1);
      exp_q.push_back(exp_q[1] + 1 + HOP_COOLDOWN + REPEAT_RATE);
      exp_q.push_back(exp_q[2] + 1 + HOP_COOLDOWN + REPEAT_RATE);
    end
    check("hold_nhops", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("hold_hop%0d_frame", i), got_q[i], exp_q[i]);
    check("hold_other_dirs", {28'd0, other_seen}, 32'd0);
    check("hold_count", {24'd0, hop_count}, exp_q.size());

    // ---- freeze during an up pulse ----
    do_reset();
    frame(16'h0052, 1'b0);
    check("frz_up_before", {31'd0, up}, 32'd1);
    freeze = 1'b1;
    @(posedge Clk); #1;
    check("frz_drop_1clk", {31'd0, up}, 32'd0);
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      frame(16'h0052, 1'b1);
      check($sformatf("frz_quiet%0d", i), {28'd0, req}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      frame(16'h0052, 1'b0);
      check($sformatf("frz_need_release%0d", i), {28'd0, req}, 32'd0);
    end
    frame(16'h0000, 1'b0);
    check("frz_released", {28'd0, req}, 32'd0);
    frame(16'h0052, 1'b0);
    check("frz_rehop", {31'd0, up}, 32'd1);
    frame(16'h0000, 1'b0);
    check("frz_count", {24'd0, hop_count}, 32'd1);

    // ---- reset mid-hop ----
    do_reset();
    frame(16'h0051, 1'b0);
    check("rmid_down", {31'd0, down}, 32'd1);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("rmid_cleared", {28'd0, req}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    frame(16'h0000, 1'b0);
    check("rmid_no_count", {24'd0, hop_count}, 32'd0);

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    begin
      int          hold;
      int          frz;
      logic [15:0] k;
      hold = 0; frz = 0; k = 16'h0000;
      for (int i = 0; i < 400; i++) begin
        if (hold == 0) begin
          k    = pick_key($urandom_range(0, 9));
          hold = $urandom_range(1, 30);
        end
        if (frz == 0 && $urandom_range(0, 39) == 0) frz = $urandom_range(1, 4);
        frame(k, frz != 0);
        model_step(k, frz != 0);
        check($sformatf("rnd%0d_req", i), {28'd0, req}, {28'd0, m_req});
        check($sformatf("rnd%0d_last", i), {28'd0, last_dir}, {28'd0, m_last});
        check($sformatf("rnd%0d_count", i), {24'd0, hop_count}, {24'd0, m_count});
        hold--;
        if (frz > 0) frz--;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
